// File: rtl/fmul_if.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_if
//  Purpose  : Operand/result handshake bundle for fmul_pipe.
//             master = operand source / result sink, slave = multiplier.
//  Revision : 1.0  initial release
// ============================================================================
interface fmul_if #(
    parameter int W = 9
);
    logic         in_valid;
    logic         in_ready;
    logic [W-1:0] a;
    logic [W-1:0] b;
    logic         out_valid;
    logic         out_ready;
    logic [W-1:0] z;
    logic         ovf;
    logic         unf;

    modport master (
        output in_valid, a, b, out_ready,
        input  in_ready, out_valid, z, ovf, unf
    );

    modport slave (
        input  in_valid, a, b, out_ready,
        output in_ready, out_valid, z, ovf, unf
    );
endinterface
`default_nettype wire

// File: rtl/fmul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : fmul_pipe
//  Purpose  : 3-stage pipelined sign/exponent/mantissa floating-point
//             multiplier with valid/ready flow control, zero handling,
//             saturating overflow and flush-to-zero underflow.
//             Build option: FMUL_RNE_EN -> round to nearest even in S2,
//             otherwise the dropped product bits are truncated.
//             The interface W parameter must equal 1+EXP_W+MAN_W.
//  Revision : 1.0  initial release
// ============================================================================
module fmul_pipe #(
    parameter int EXP_W = 3,
    parameter int MAN_W = 5,
    parameter int BIAS  = 4
) (
    input  wire logic clk,
    input  wire logic rst_n,
    fmul_if.slave     bus
);
    localparam int W  = 1 + EXP_W + MAN_W;
    localparam int PW = 2 * MAN_W + 2;     // full significand product width
    localparam int EW = EXP_W + 3;         // S2 exponent: room for +1 normalise and +1 round carry

    localparam logic signed [EXP_W+1:0] c_bias = (EXP_W+2)'(BIAS);
    localparam logic signed [EW-1:0]    c_emax = EW'((1 << EXP_W) - 1);
    localparam logic signed [EW-1:0]    c_emin = EW'(1);

    // ---------------- handshake ----------------
    logic r_s1_valid, r_s2_valid, r_out_valid;
    logic w_ld1, w_ld2, w_ld3;

    // A stage loads when it is empty or the stage after it is loading.
    assign w_ld3 = !r_out_valid || bus.out_ready;
    assign w_ld2 = !r_s2_valid  || w_ld3;
    assign w_ld1 = !r_s1_valid  || w_ld2;

    assign bus.in_ready = rst_n && w_ld1;

    // ---------------- stage 1: sign, zero, exponent sum, product ----------------
    logic [EXP_W-1:0]         w_a_exp, w_b_exp;
    logic [MAN_W-1:0]         w_a_man, w_b_man;
    logic signed [EXP_W+1:0]  w_esum;
    logic [PW-1:0]            w_prod;

    assign w_a_exp = bus.a[W-2:MAN_W];
    assign w_b_exp = bus.b[W-2:MAN_W];
    assign w_a_man = bus.a[MAN_W-1:0];
    assign w_b_man = bus.b[MAN_W-1:0];
    assign w_esum  = $signed({2'b00, w_a_exp}) + $signed({2'b00, w_b_exp}) - c_bias;
    assign w_prod  = PW'({1'b1, w_a_man}) * PW'({1'b1, w_b_man});

    logic                     r_s1_sign, r_s1_zero;
    logic signed [EXP_W+1:0]  r_s1_esum;
    logic [PW-1:0]            r_s1_prod;

    // S1 register: capture operands' derived fields on accept.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s1_valid <= 1'b0;
            r_s1_sign  <= 1'b0;
            r_s1_zero  <= 1'b0;
            r_s1_esum  <= '0;
            r_s1_prod  <= '0;
        end else if (w_ld1) begin
            r_s1_valid <= bus.in_valid;
            if (bus.in_valid) begin
                r_s1_sign <= bus.a[W-1] ^ bus.b[W-1];
                r_s1_zero <= (w_a_exp == '0) || (w_b_exp == '0);
                r_s1_esum <= w_esum;
                r_s1_prod <= w_prod;
            end
        end
    end

    // ---------------- stage 2: normalise and round ----------------
    logic                 w_msb;
    logic signed [EW-1:0] w_e_norm, w_s2_e;
    logic [MAN_W-1:0]     w_man_trunc, w_s2_man;

    assign w_msb       = r_s1_prod[PW-1];
    assign w_e_norm    = {r_s1_esum[EXP_W+1], r_s1_esum} + {{(EW-1){1'b0}}, w_msb};
    assign w_man_trunc = w_msb ? r_s1_prod[2*MAN_W:MAN_W+1] : r_s1_prod[2*MAN_W-1:MAN_W];

`ifdef FMUL_RNE_EN
    logic             w_guard, w_sticky, w_inc;
    logic [MAN_W:0]   w_man_rnd;

    assign w_guard   = w_msb ? r_s1_prod[MAN_W]       : r_s1_prod[MAN_W-1];
    assign w_sticky  = w_msb ? |r_s1_prod[MAN_W-1:0]  : |r_s1_prod[MAN_W-2:0];
    assign w_inc     = w_guard && (w_sticky || w_man_trunc[0]);
    assign w_man_rnd = {1'b0, w_man_trunc} + {{MAN_W{1'b0}}, w_inc};
    // A carry out leaves the stored mantissa at zero; only the exponent moves.
    assign w_s2_man  = w_man_rnd[MAN_W-1:0];
    assign w_s2_e    = w_e_norm + {{(EW-1){1'b0}}, w_man_rnd[MAN_W]};
`else
    logic w_unused_low;
    assign w_unused_low = ^r_s1_prod[MAN_W-1:0];
    assign w_s2_man     = w_man_trunc;
    assign w_s2_e       = w_e_norm;
`endif

    logic                 r_s2_sign, r_s2_zero;
    logic signed [EW-1:0] r_s2_e;
    logic [MAN_W-1:0]     r_s2_man;

    // S2 register: normalised exponent and mantissa.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_s2_valid <= 1'b0;
            r_s2_sign  <= 1'b0;
            r_s2_zero  <= 1'b0;
            r_s2_e     <= '0;
            r_s2_man   <= '0;
        end else if (w_ld2) begin
            r_s2_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_s2_sign <= r_s1_sign;
                r_s2_zero <= r_s1_zero;
                r_s2_e    <= w_s2_e;
                r_s2_man  <= w_s2_man;
            end
        end
    end

    // ---------------- stage 3: exceptions and output register ----------------
    logic [W-1:0] w_z_next;
    logic         w_ovf_next, w_unf_next;

    // Exception priority: zero operand, overflow, underflow, normal.
    always_comb begin
        w_z_next   = {r_s2_sign, {(W-1){1'b0}}};
        w_ovf_next = 1'b0;
        w_unf_next = 1'b0;
        if (r_s2_zero) begin
            w_z_next = {r_s2_sign, {(W-1){1'b0}}};
        end else if (r_s2_e > c_emax) begin
            w_z_next   = {r_s2_sign, {(W-1){1'b1}}};
            w_ovf_next = 1'b1;
        end else if (r_s2_e < c_emin) begin
            w_unf_next = 1'b1;
        end else begin
            w_z_next = {r_s2_sign, r_s2_e[EXP_W-1:0], r_s2_man};
        end
    end

    logic [W-1:0] r_z;
    logic         r_ovf, r_unf;

    // Output register: holds its value while the consumer stalls.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_out_valid <= 1'b0;
            r_z         <= '0;
            r_ovf       <= 1'b0;
            r_unf       <= 1'b0;
        end else if (w_ld3) begin
            r_out_valid <= r_s2_valid;
            if (r_s2_valid) begin
                r_z   <= w_z_next;
                r_ovf <= w_ovf_next;
                r_unf <= w_unf_next;
            end
        end
    end

    assign bus.out_valid = r_out_valid;
    assign bus.z         = r_z;
    assign bus.ovf       = r_ovf;
    assign bus.unf       = r_unf;
endmodule
`default_nettype wire

// File: tb/tb_fmul_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : tb_fmul_pipe
//  Purpose  : Scoreboard bench for fmul_pipe (1-3-5, bias 4): directed
//             values, backpressure, mid-operation reset and random traffic
//             against an arithmetic reference model. Honours FMUL_RNE_EN.
//  Revision : 1.0  initial release
// ============================================================================
module tb_fmul_pipe;
    localparam int EXP_W = 3;
    localparam int MAN_W = 5;
    localparam int BIAS  = 4;
    localparam int W     = 1 + EXP_W + MAN_W;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    fmul_if #(.W(W)) bus ();

    fmul_pipe #(.EXP_W(EXP_W), .MAN_W(MAN_W), .BIAS(BIAS)) u_dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    int tests  = 0;
    int errors = 0;
    logic [W+1:0] exp_q [$];   // {z, ovf, unf}

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        tests++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, req);
        end
    endtask

    // Reference: value arithmetic on integer significands, scaled by 2^(2*MAN_W).
    function automatic logic [W+1:0] ref_mul(input logic [W-1:0] a, input logic [W-1:0] b);
        int ea, eb, e, prod, shift, mf;
        logic s;
`ifdef FMUL_RNE_EN
        int rem, half;
`endif
        s  = a[W-1] ^ b[W-1];
        ea = int'(a[W-2:MAN_W]);
        eb = int'(b[W-2:MAN_W]);
        if (ea == 0 || eb == 0) return {s, {(W-1){1'b0}}, 2'b00};
        prod = ((1 << MAN_W) + int'(a[MAN_W-1:0])) * ((1 << MAN_W) + int'(b[MAN_W-1:0]));
        e = ea + eb - BIAS;
        if (prod >= (2 << (2 * MAN_W))) begin
            e++;
            shift = MAN_W + 1;
        end else begin
            shift = MAN_W;
        end
        mf = prod >> shift;
`ifdef FMUL_RNE_EN
        rem  = prod - (mf << shift);
        half = 1 << (shift - 1);
        if (rem > half || (rem == half && (mf % 2) == 1)) mf++;
`endif
        if (mf == (2 << MAN_W)) begin
            mf = 1 << MAN_W;
            e++;
        end
        if (e > (1 << EXP_W) - 1) return {s, {(W-1){1'b1}}, 2'b10};
        if (e < 1)                return {s, {(W-1){1'b0}}, 2'b01};
        return {s, e[EXP_W-1:0], mf[MAN_W-1:0], 2'b00};
    endfunction

    // Drive one cycle at the falling edge; record the expected result on accept.
    task automatic drive(input logic v, input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic ordy, input logic [W+1:0] want, output logic acc);
        @(negedge clk);
        bus.in_valid  = v;
        bus.a         = a;
        bus.b         = b;
        bus.out_ready = ordy;
        #1;
        acc = v && bus.in_ready;
        if (acc) exp_q.push_back(want);
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        drive(1'b0, '0, '0, ordy, '0, acc);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 60) begin
            idle(1'b1);
            n++;
        end
        idle(1'b1);
        check("drain_empty", exp_q.size(), 0);
    endtask

    task automatic latency_probe(input logic [W-1:0] a, input logic [W-1:0] b,
                                 input logic [W+1:0] want, input string name);
        logic acc;
        int cnt = 0;
        drive(1'b1, a, b, 1'b1, want, acc);
        check({name, "_accept"}, acc, 1);
        while (!bus.out_valid && cnt < 10) begin
            idle(1'b1);
            cnt++;
        end
        check(name, cnt, 3);
    endtask

    // Monitor: pops and compares on every output transfer; checks hold while stalled.
    initial begin : monitor
        logic         prev_stall;
        logic [W+1:0] prev_out, got, want;
        prev_stall = 1'b0;
        prev_out   = '0;
        forever begin
            @(negedge clk);
            #2;
            got = {bus.z, bus.ovf, bus.unf};
            if (prev_stall && bus.out_valid) check("hold_stable", got, prev_out);
            if (bus.out_valid && bus.out_ready) begin
                if (exp_q.size() == 0) begin
                    tests++;
                    errors++;
                    $display("FAIL unexpected_output: got %0h, expected none", got);
                end else begin
                    want = exp_q.pop_front();
                    check("result", got, want);
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = got;
        end
    end

    initial begin : watchdog
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    logic [W-1:0] dir_a [8] = '{9'h090, 9'h180, 9'h000, 9'h0FF, 9'h020, 9'h1FF, 9'h085, 9'h081};
    logic [W-1:0] dir_b [8] = '{9'h090, 9'h090, 9'h0FF, 9'h0FF, 9'h020, 9'h0FF, 9'h085, 9'h090};
`ifdef FMUL_RNE_EN
    logic [W+1:0] dir_z [8] = '{{9'h0A4, 2'b00}, {9'h190, 2'b00}, {9'h000, 2'b00}, {9'h0FF, 2'b10},
                                {9'h000, 2'b01}, {9'h1FF, 2'b10}, {9'h08B, 2'b00}, {9'h092, 2'b00}};
`else
    logic [W+1:0] dir_z [8] = '{{9'h0A4, 2'b00}, {9'h190, 2'b00}, {9'h000, 2'b00}, {9'h0FF, 2'b10},
                                {9'h000, 2'b01}, {9'h1FF, 2'b10}, {9'h08A, 2'b00}, {9'h091, 2'b00}};
`endif
    logic [W-1:0] bp_a [6] = '{9'h090, 9'h0A5, 9'h1B3, 9'h0C7, 9'h08E, 9'h0D1};
    logic [W-1:0] bp_b [6] = '{9'h0A4, 9'h098, 9'h09F, 9'h0B1, 9'h1C2, 9'h086};

    initial begin : main
        logic acc, dropped, v, ordy;
        logic [W-1:0] ra, rb;
        int idx, nout, stale, k;

        bus.in_valid  = 1'b0;
        bus.a         = '0;
        bus.b         = '0;
        bus.out_ready = 1'b1;

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        check("rst_out_valid", bus.out_valid, 0);
        check("rst_z",         bus.z, 0);
        check("rst_ovf",       bus.ovf, 0);
        check("rst_unf",       bus.unf, 0);
        check("rst_in_ready",  bus.in_ready, 0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("in_ready_after_rst", bus.in_ready, 1);

        // Latency with out_ready high
        latency_probe(9'h090, 9'h090, {9'h0A4, 2'b00}, "latency");
        drain();

        // Directed values streamed back to back
        for (int i = 0; i < 8; i++) begin
            k = 0;
            do begin
                drive(1'b1, dir_a[i], dir_b[i], 1'b1, dir_z[i], acc);
                k++;
            end while (!acc && k < 20);
        end
        drain();

        // Backpressure: out_ready low for cycles 2..7
        idx = 0; nout = 0; dropped = 1'b0;
        for (int c = 0; c < 20; c++) begin
            v    = (idx < 6);
            ordy = !(c >= 2 && c <= 7);
            k    = (idx < 6) ? idx : 5;
            drive(v, bp_a[k], bp_b[k], ordy, ref_mul(bp_a[k], bp_b[k]), acc);
            if (acc) idx++;
            if (v && !bus.in_ready && !dropped) begin
                dropped = 1'b1;
                check("accepts_before_stall", idx, 3);
            end
            if (c >= 8 && c <= 13 && bus.out_valid && bus.out_ready) nout++;
        end
        check("stall_seen", dropped, 1);
        check("drain_one_per_cycle", nout, 6);
        drain();

        // Reset with two results in flight (one in the output register)
        drive(1'b1, 9'h0FF, 9'h0FF, 1'b1, ref_mul(9'h0FF, 9'h0FF), acc);
        drive(1'b1, 9'h085, 9'h085, 1'b1, ref_mul(9'h085, 9'h085), acc);
        idle(1'b1);
        idle(1'b0);
        check("pre_rst_ovf", bus.ovf, 1);
        #2;
        rst_n = 1'b0;
        #1;
        exp_q.delete();
        check("midrst_out_valid", bus.out_valid, 0);
        check("midrst_z",         bus.z, 0);
        check("midrst_ovf",       bus.ovf, 0);
        check("midrst_unf",       bus.unf, 0);
        idle(1'b1);
        @(negedge clk);
        rst_n = 1'b1;
        stale = 0;
        for (int c = 0; c < 5; c++) begin
            idle(1'b1);
            if (bus.out_valid) stale++;
        end
        check("no_stale_after_rst", stale, 0);
        latency_probe(9'h020, 9'h020, {9'h000, 2'b01}, "latency_after_rst");
        drain();

        // Random traffic against the reference model
        for (int c = 0; c < 500; c++) begin
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            ra   = W'($urandom);
            rb   = W'($urandom);
            drive(v, ra, rb, ordy, ref_mul(ra, rb), acc);
        end
        drain();

        $display("[TB] %0d tests run, %0d failed", tests, errors);
        $finish;
    end
endmodule
`default_nettype wire
